// File: rtl/robo_pkg.sv
// Shared definitions for the robot navigation controller: FSM state
// encodings and default timing constants.
package robo_pkg;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_FWD    = 3'd1,
    S_TURN_L = 3'd2,
    S_TURN_R = 3'd3,
    S_STOP   = 3'd4,
    S_LOWBAT = 3'd5
  } state_e;

  localparam int unsigned DEB_CYCLES_DEF  = 16;
  localparam int unsigned TURN_CYCLES_DEF = 1000;
  localparam int unsigned BLINK_HALF_DEF  = 500000;

endpackage

// File: rtl/robo_debounce.sv
// Two-flop synchronizer followed by a debouncer. The debounced output only
// takes the synchronized value after DEB_CYCLES consecutive cycles in which
// the two disagree; any return to agreement clears the counter.
module robo_debounce
  import robo_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic deb_o
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count cycles of disagreement; commit the new value on the last one.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, debounced value and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/robo_nav_seq.sv
// Sequential navigation controller: synchronizes/debounces key and sensor
// inputs and drives wheels and LEDs from a Moore FSM with held turns.
// Optional build macro ROBO_LOWBAT_BLINK_EN: blink LedR while in LOWBAT.
module robo_nav_seq
  import robo_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int unsigned TURN_CYCLES = TURN_CYCLES_DEF
`ifdef ROBO_LOWBAT_BLINK_EN
  ,
  parameter int unsigned BLINK_HALF  = BLINK_HALF_DEF
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CH,
  input  logic       BF,
  input  logic       SF,
  input  logic       SD,
  input  logic       SE,
  input  logic       ST,
  output logic       CE,
  output logic       CD,
  output logic       LedR,
  output logic       LedG,
  output logic       RE,
  output logic       RD,
  output logic [2:0] STATE
);

  localparam int unsigned TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

  logic ch_s1_q, ch_s2_q;
  logic bf_deb, sf_deb, sd_deb, se_deb, st_deb;
  logic left, right, blocked;

  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic re_q, rd_q, ce_q, cd_q, led_r_q, led_g_q;
  logic re_d, rd_d, ce_d, cd_d, led_r_d, led_g_d;

  // Key input is only synchronized, never debounced.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ch_s1_q <= 1'b0;
      ch_s2_q <= 1'b0;
    end else begin
      ch_s1_q <= CH;
      ch_s2_q <= ch_s1_q;
    end
  end

  robo_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_bf (.clk_i(CLK), .rst_i(RST), .raw_i(BF), .deb_o(bf_deb));
  robo_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sf (.clk_i(CLK), .rst_i(RST), .raw_i(SF), .deb_o(sf_deb));
  robo_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sd (.clk_i(CLK), .rst_i(RST), .raw_i(SD), .deb_o(sd_deb));
  robo_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_se (.clk_i(CLK), .rst_i(RST), .raw_i(SE), .deb_o(se_deb));
  robo_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_st (.clk_i(CLK), .rst_i(RST), .raw_i(ST), .deb_o(st_deb));

  // Steering decode; forward (~SF) is the fall-through of the priority chain.
  assign left    = sf_deb & sd_deb & (~se_deb | st_deb);
  assign right   = sf_deb & (~sd_deb | se_deb);
  assign blocked = left & right;

  // Next-state selection in priority order, plus turn-hold counter.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    if (!ch_s2_q) begin
      state_d = S_OFF;
      tcnt_d  = '0;
    end else if (bf_deb) begin
      state_d = S_LOWBAT;
      tcnt_d  = '0;
    end else if ((state_q == S_TURN_L || state_q == S_TURN_R) && (tcnt_q < TURN_LAST)) begin
      tcnt_d = tcnt_q + 1'b1;
    end else begin
      tcnt_d = '0;
      if (blocked)    state_d = S_STOP;
      else if (left)  state_d = S_TURN_L;
      else if (right) state_d = S_TURN_R;
      else            state_d = S_FWD;
    end
  end

`ifdef ROBO_LOWBAT_BLINK_EN
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          lowbat_red;

  // Blink phase: LedR is set on entry and flips after each BLINK_HALF cycles.
  always_comb begin
    bcnt_d     = '0;
    lowbat_red = 1'b1;
    if (state_d == S_LOWBAT && state_q == S_LOWBAT) begin
      if (bcnt_q == BLINK_LAST) begin
        lowbat_red = ~led_r_q;
      end else begin
        bcnt_d     = bcnt_q + 1'b1;
        lowbat_red = led_r_q;
      end
    end
  end

  // Blink counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) bcnt_q <= '0;
    else     bcnt_q <= bcnt_d;
  end
`else
  logic lowbat_red;
  assign lowbat_red = 1'b1;
`endif

  // Moore output decode from the next state, so outputs move with the state.
  always_comb begin
    re_d    = 1'b0;
    rd_d    = 1'b0;
    ce_d    = 1'b0;
    cd_d    = 1'b0;
    led_r_d = 1'b0;
    led_g_d = 1'b0;
    unique case (state_d)
      S_FWD: begin
        re_d = 1'b1; rd_d = 1'b1; ce_d = 1'b1; cd_d = 1'b1;
      end
      S_TURN_L: begin
        rd_d = 1'b1; ce_d = 1'b1;
      end
      S_TURN_R: begin
        re_d = 1'b1; cd_d = 1'b1;
      end
      S_STOP:   led_r_d = 1'b1;
      S_LOWBAT: begin
        led_r_d = lowbat_red;
        led_g_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, turn counter and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_OFF;
      tcnt_q  <= '0;
      re_q    <= 1'b0;
      rd_q    <= 1'b0;
      ce_q    <= 1'b0;
      cd_q    <= 1'b0;
      led_r_q <= 1'b0;
      led_g_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      re_q    <= re_d;
      rd_q    <= rd_d;
      ce_q    <= ce_d;
      cd_q    <= cd_d;
      led_r_q <= led_r_d;
      led_g_q <= led_g_d;
    end
  end

  assign RE    = re_q;
  assign RD    = rd_q;
  assign CE    = ce_q;
  assign CD    = cd_q;
  assign LedR  = led_r_q;
  assign LedG  = led_g_q;
  assign STATE = state_q;

endmodule
